// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage with PC, registered fetch/decode slot,
// redirect flush and sticky halt.
module fetch_unit #(
    parameter int            AW       = 6,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic [AW-1:0] imem_addr,
    input  logic [31:0]   imem_data,
    input  logic          redirect_valid,
    input  logic [AW-1:0] redirect_pc,
    input  logic          halt,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [31:0]   out_instr,
    output logic [AW-1:0] out_pc,
    output logic [AW-1:0] out_pc_next,
    output logic          halted,
    output logic [15:0]   fetch_count
);
    typedef enum logic {RUN, HALT} state_t;

    state_t        r_state, w_state_next;
    logic [AW-1:0] r_pc, r_out_pc, r_out_pc_next, w_pc_inc;
    logic [31:0]   r_instr;
    logic [15:0]   r_count;
    logic          r_valid, w_take, w_room, w_redirect, w_load;

    always_comb begin
        w_take       = r_valid & out_ready;
        w_room       = !r_valid | out_ready;
        w_pc_inc     = r_pc + 1'b1;
        w_state_next = r_state;
        w_redirect   = 1'b0;
        w_load       = 1'b0;
        if (r_state == RUN) begin
            if (halt)
                w_state_next = HALT;
            else if (redirect_valid)
                w_redirect = 1'b1;
            else
                w_load = w_room;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= RUN;
            r_pc          <= RESET_PC;
            r_valid       <= 1'b0;
            r_instr       <= '0;
            r_out_pc      <= '0;
            r_out_pc_next <= '0;
            r_count       <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_redirect) begin
                r_pc    <= redirect_pc;
                r_valid <= 1'b0;
            end else if (w_load) begin
                r_instr       <= imem_data;
                r_out_pc      <= r_pc;
                r_out_pc_next <= w_pc_inc;
                r_valid       <= 1'b1;
                r_pc          <= w_pc_inc;
                r_count       <= r_count + 16'd1;
            end else if (w_take) begin
                // Reached only while halting/halted: the slot drains and is never refilled.
                r_valid <= 1'b0;
            end
        end
    end

    assign imem_addr   = r_pc;
    assign out_valid   = r_valid;
    assign out_instr   = r_instr;
    assign out_pc      = r_out_pc;
    assign out_pc_next = r_out_pc_next;
    assign halted      = (r_state == HALT);
    assign fetch_count = r_count;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenarios plus randomized traffic against a behavioural model.
module tb_fetch_unit;
    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_data;
    logic          redirect_valid = 1'b0;
    logic [AW-1:0] redirect_pc = '0;
    logic          halt = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [31:0]   out_instr;
    logic [AW-1:0] out_pc, out_pc_next;
    logic          halted;
    logic [15:0]   fetch_count;

    logic [31:0]   mem [0:63];
    int checks = 0;
    int errors = 0;

    logic          m_valid, m_halted;
    logic [AW-1:0] m_pc, m_opc, m_opcn;
    logic [31:0]   m_instr;
    logic [15:0]   m_cnt;

    fetch_unit #(.AW(AW), .RESET_PC('0)) dut (
        .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_data(imem_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt(halt),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_pc(out_pc), .out_pc_next(out_pc_next), .halted(halted),
        .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;
    assign imem_data = mem[imem_addr];

    task automatic model_reset();
        m_valid = 0; m_halted = 0; m_pc = '0; m_opc = '0; m_opcn = '0;
        m_instr = '0; m_cnt = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 0; halt = 0; redirect_valid = 0; redirect_pc = '0; out_ready = 1;
        #3;
        model_reset();
        @(negedge clk);
        rst_n = 1;
    endtask

    // Apply inputs for one cycle, advance the model across the edge, settle 1ns after it.
    task automatic drive_cycle(input logic h, input logic rv, input logic [AW-1:0] rpc, input logic rdy);
        logic take, room;
        halt = h; redirect_valid = rv; redirect_pc = rpc; out_ready = rdy;
        @(posedge clk);
        take = m_valid & rdy;
        room = !m_valid | rdy;
        if (m_halted || h) begin
            m_halted = 1;
            if (take) m_valid = 0;
        end else if (rv) begin
            m_pc = rpc; m_valid = 0;
        end else if (room) begin
            m_instr = mem[m_pc]; m_opc = m_pc; m_opcn = m_pc + 1'b1;
            m_valid = 1; m_pc = m_pc + 1'b1; m_cnt = m_cnt + 16'd1;
        end
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (imem_addr !== 6'd0 || out_valid !== 1'b0 || out_instr !== 32'd0 || out_pc !== 6'd0 ||
            out_pc_next !== 6'd0 || halted !== 1'b0 || fetch_count !== 16'd0) begin
            errors++;
            $display("FAIL reset got addr=%0d v=%b instr=%h pc=%0d pcn=%0d h=%b cnt=%0d exp all zero",
                     imem_addr, out_valid, out_instr, out_pc, out_pc_next, halted, fetch_count);
        end
    endtask

    task automatic test_stream();
        logic [31:0] exp_i [0:1];
        exp_i[0] = 32'h00001820; exp_i[1] = 32'h2001000A;
        for (int i = 0; i < 2; i++) begin
            drive_cycle(0, 0, '0, 1);
            checks++;
            if (out_valid !== 1'b1 || out_instr !== exp_i[i] || out_pc !== AW'(i) || fetch_count !== 16'(i + 1)) begin
                errors++;
                $display("FAIL stream edge%0d got v=%b instr=%h pc=%0d cnt=%0d exp v=1 instr=%h pc=%0d cnt=%0d",
                         i + 1, out_valid, out_instr, out_pc, fetch_count, exp_i[i], i, i + 1);
            end
        end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 4; i++) begin
            drive_cycle(0, 0, '0, 0);
            checks++;
            if (out_valid !== 1'b1 || out_instr !== 32'h2001000A || out_pc !== 6'd1 ||
                imem_addr !== 6'd2 || fetch_count !== 16'd2) begin
                errors++;
                $display("FAIL stall cyc%0d got v=%b instr=%h pc=%0d addr=%0d cnt=%0d exp 1 2001000a 1 2 2",
                         i, out_valid, out_instr, out_pc, imem_addr, fetch_count);
            end
        end
        drive_cycle(0, 0, '0, 1);
        checks++;
        if (out_pc !== 6'd2 || out_instr !== 32'h00231820 || fetch_count !== 16'd3) begin
            errors++;
            $display("FAIL stall_release got pc=%0d instr=%h cnt=%0d exp 2 00231820 3", out_pc, out_instr, fetch_count);
        end
    endtask

    task automatic test_redirect();
        for (int i = 0; i < 4; i++) drive_cycle(0, 0, '0, 1);
        checks++;
        if (out_pc !== 6'd6 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL redirect_setup got pc=%0d v=%b exp 6 1", out_pc, out_valid);
        end
        drive_cycle(0, 1, 6'd2, 1);
        checks++;
        if (out_valid !== 1'b0 || imem_addr !== 6'd2 || fetch_count !== 16'd7) begin
            errors++;
            $display("FAIL redirect_flush got v=%b addr=%0d cnt=%0d exp 0 2 7", out_valid, imem_addr, fetch_count);
        end
        drive_cycle(0, 0, '0, 1);
        checks++;
        if (out_valid !== 1'b1 || out_instr !== 32'h00231820 || out_pc !== 6'd2) begin
            errors++;
            $display("FAIL redirect_target got v=%b instr=%h pc=%0d exp 1 00231820 2", out_valid, out_instr, out_pc);
        end
    endtask

    task automatic test_wrap();
        drive_cycle(0, 1, 6'd63, 1);
        drive_cycle(0, 0, '0, 1);
        checks++;
        if (out_pc !== 6'd63 || out_pc_next !== 6'd0 || out_instr !== mem[63] || imem_addr !== 6'd0) begin
            errors++;
            $display("FAIL wrap_63 got pc=%0d pcn=%0d instr=%h addr=%0d exp 63 0 %h 0",
                     out_pc, out_pc_next, out_instr, imem_addr, mem[63]);
        end
        drive_cycle(0, 0, '0, 1);
        checks++;
        if (out_pc !== 6'd0 || out_pc_next !== 6'd1 || out_instr !== 32'h00001820) begin
            errors++;
            $display("FAIL wrap_0 got pc=%0d pcn=%0d instr=%h exp 0 1 00001820", out_pc, out_pc_next, out_instr);
        end
    endtask

    task automatic test_halt();
        logic [15:0] cnt0;
        cnt0 = fetch_count;
        drive_cycle(1, 1, 6'd10, 0);
        checks++;
        if (halted !== 1'b1 || imem_addr !== 6'd1 || out_valid !== 1'b1 || out_pc !== 6'd0 || fetch_count !== cnt0) begin
            errors++;
            $display("FAIL halt_enter got h=%b addr=%0d v=%b pc=%0d cnt=%0d exp 1 1 1 0 %0d",
                     halted, imem_addr, out_valid, out_pc, fetch_count, cnt0);
        end
        for (int i = 0; i < 5; i++) begin
            drive_cycle(0, 1'($urandom_range(0, 1)), 6'($urandom), 1);
            checks++;
            if (out_valid !== 1'b0 || halted !== 1'b1 || imem_addr !== 6'd1 || fetch_count !== cnt0) begin
                errors++;
                $display("FAIL halt_drain cyc%0d got v=%b h=%b addr=%0d cnt=%0d exp 0 1 1 %0d",
                         i, out_valid, halted, imem_addr, fetch_count, cnt0);
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 5; i++) drive_cycle(0, 0, '0, 1);
        checks++;
        if (imem_addr !== 6'd5 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL areset_setup got addr=%0d v=%b exp 5 1", imem_addr, out_valid);
        end
        #3 rst_n = 0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || imem_addr !== 6'd0 || fetch_count !== 16'd0 || halted !== 1'b0) begin
            errors++;
            $display("FAIL areset got v=%b addr=%0d cnt=%0d h=%b exp 0 0 0 0", out_valid, imem_addr, fetch_count, halted);
        end
        do_reset();
    endtask

    task automatic test_random();
        int halt_cycles = 0;
        for (int c = 0; c < 600; c++) begin
            drive_cycle($urandom_range(0, 63) == 0, $urandom_range(0, 7) == 0, 6'($urandom), $urandom_range(0, 9) < 7);
            checks++;
            if ({out_valid, out_instr, out_pc, out_pc_next, imem_addr, halted, fetch_count} !==
                {m_valid, m_instr, m_opc, m_opcn, m_pc, m_halted, m_cnt}) begin
                errors++;
                $display("FAIL random cyc%0d got v=%b i=%h pc=%0d pcn=%0d a=%0d h=%b n=%0d exp v=%b i=%h pc=%0d pcn=%0d a=%0d h=%b n=%0d",
                         c, out_valid, out_instr, out_pc, out_pc_next, imem_addr, halted, fetch_count,
                         m_valid, m_instr, m_opc, m_opcn, m_pc, m_halted, m_cnt);
            end
            halt_cycles = m_halted ? halt_cycles + 1 : 0;
            if (halt_cycles > 8) begin
                do_reset();
                halt_cycles = 0;
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        mem[0] = 32'h00001820; mem[1] = 32'h2001000A; mem[2] = 32'h00231820;
        model_reset();
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_wrap();
        test_halt();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
